// File: rtl/serdes_pkg.sv
// Shared definitions for the serdes transmit path: idle level, K flag
// encoding, shifter state encoding and a constant clog2 helper.
package serdes_pkg;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  localparam logic K_CHAR = 1'b1;
  localparam logic K_DATA = 1'b0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Width needed to count 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding buffer for {k, data}. Only the full flag is reset;
// the stored word is meaningless while the buffer is empty.
module ser_hold_reg
  import serdes_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             in_k,
  input  logic [WIDTH-1:0] in_data,
  output logic             full,
  output logic             out_k,
  output logic [WIDTH-1:0] out_data
);

  logic           full_q, full_d;
  logic [WIDTH:0] word_q, word_d;

  always_comb begin
    full_d = full_q;
    word_d = word_q;
    if (pop) full_d = 1'b0;
    if (push) begin
      full_d = 1'b1;
      word_d = {in_k, in_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) full_q <= 1'b0;
    else       full_q <= full_d;
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign full     = full_q;
  assign out_k    = word_q[WIDTH];
  assign out_data = word_q[WIDTH-1:0];

endmodule

// File: rtl/serializer_param.sv
// Parametrised parallel-to-serial converter: valid/ready word input into a
// one-entry hold, gapless serial output with frame_start, K flag and underrun.
module serializer_param
  import serdes_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_k,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             k_out,
  output logic             underrun
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_q, frame_d;
  logic             k_q, k_d;
  logic             underrun_q, underrun_d;
  logic             rdy_q, rdy_d;

  logic             hold_full, hold_k;
  logic [WIDTH-1:0] hold_data;
  logic             need, xfer, load, push, pop, ld_k;
  logic [WIDTH-1:0] ld_data;

  function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
    if (MSB_FIRST) return w[LAST - idx];
    else           return w[idx];
  endfunction

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .in_k     (in_k),
    .in_data  (in_data),
    .full     (hold_full),
    .out_k    (hold_k),
    .out_data (hold_data)
  );

  // rdy_q keeps in_ready low through reset without a combinational path from reset.
  assign in_ready = rdy_q & ~hold_full;
  assign xfer     = in_valid & in_ready;
  assign need     = (state_q == ST_IDLE) || (cnt_q == LAST);
  assign pop      = need & hold_full;
  assign load     = pop | (need & xfer);
  assign push     = xfer & ~need;
  assign ld_k     = pop ? hold_k : in_k;
  assign ld_data  = pop ? hold_data : in_data;
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    frame_d     = 1'b0;
    k_d         = k_q;
    underrun_d  = 1'b0;
    rdy_d       = 1'b1;
    if (load) begin
      state_d     = ST_SHIFT;
      cnt_d       = '0;
      word_d      = ld_data;
      ser_out_d   = pick_bit(ld_data, '0);
      ser_valid_d = 1'b1;
      frame_d     = 1'b1;
      k_d         = ld_k;
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q == LAST) begin
        state_d     = ST_IDLE;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        k_d         = 1'b0;
        underrun_d  = 1'b1;
      end else begin
        cnt_d     = cnt_inc;
        ser_out_d = pick_bit(word_q, cnt_inc);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ser_out_q   <= IDLE_BIT;
      ser_valid_q <= 1'b0;
      frame_q     <= 1'b0;
      k_q         <= 1'b0;
      underrun_q  <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      frame_q     <= frame_d;
      k_q         <= k_d;
      underrun_q  <= underrun_d;
      rdy_q       <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_q;
  assign k_out       = k_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_serializer_param.sv
// Scoreboard bench for serializer_param: one MSB-first and one LSB-first instance,
// expected bit streams queued by the stimulus and popped by per-instance monitors.
module tb_serializer_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_valid = 1'b0, l_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_k = 1'b0;

  logic m_rdy, m_so, m_sv, m_fs, m_ko, m_ur;
  logic l_rdy, l_so, l_sv, l_fs, l_ko, l_ur;

  serializer_param #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .reset(reset), .in_valid(m_valid), .in_data(in_data), .in_k(in_k),
    .in_ready(m_rdy), .ser_out(m_so), .ser_valid(m_sv), .frame_start(m_fs),
    .k_out(m_ko), .underrun(m_ur)
  );

  serializer_param #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_valid(l_valid), .in_data(in_data), .in_k(in_k),
    .in_ready(l_rdy), .ser_out(l_so), .ser_valid(l_sv), .frame_start(l_fs),
    .k_out(l_ko), .underrun(l_ur)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic f;
    logic k;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];
  exp_t e_m, e_l;
  int   errors = 0, checks = 0;
  int   cyc = 0;
  int   und_m = 0, und_l = 0, vcnt_m = 0, vcnt_l = 0;
  int   last_start_m = -1;
  logic prev_v_m = 1'b0, prev_v_l = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // bits/frames/ks: bit n-1 is the first in time
  task automatic push_exp(input bit sel, input logic [31:0] bits, input int n,
                          input logic [31:0] frames, input logic [31:0] ks);
    exp_t e;
    for (int i = n - 1; i >= 0; i--) begin
      e = '{b: bits[i], f: frames[i], k: ks[i]};
      if (sel) q_l.push_back(e);
      else     q_m.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] d, input logic k, output int acc_cyc);
    int t;
    t = 0;
    in_data = d;
    in_k    = k;
    if (sel) l_valid = 1'b1;
    else     m_valid = 1'b1;
    while (!(sel ? l_rdy : m_rdy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("accept_timeout", t, 0);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic drain(input bit sel);
    int t;
    t = 0;
    while (((sel ? q_l.size() : q_m.size()) != 0 || (sel ? l_sv : m_sv)) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("drain_timeout", t, 0);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (m_sv) begin
        vcnt_m++;
        if (m_fs) last_start_m = cyc;
        chk("m_stream_expected", (q_m.size() != 0), 1);
        if (q_m.size() != 0) begin
          e_m = q_m.pop_front();
          chk("m_bit_frame_k", {m_so, m_fs, m_ko}, e_m);
        end
      end else begin
        chk("m_idle_outputs", {m_so, m_fs, m_ko}, 3'b000);
        if (prev_v_m) chk("m_gap_pending_bits", q_m.size(), 0);
      end
      if (m_ur) begin
        und_m++;
        chk("m_underrun_position", {prev_v_m, m_sv}, 2'b10);
      end
      prev_v_m = m_sv;
    end else prev_v_m = 1'b0;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (l_sv) begin
        vcnt_l++;
        chk("l_stream_expected", (q_l.size() != 0), 1);
        if (q_l.size() != 0) begin
          e_l = q_l.pop_front();
          chk("l_bit_frame_k", {l_so, l_fs, l_ko}, e_l);
        end
      end else begin
        chk("l_idle_outputs", {l_so, l_fs, l_ko}, 3'b000);
        if (prev_v_l) chk("l_gap_pending_bits", q_l.size(), 0);
      end
      if (l_ur) begin
        und_l++;
        chk("l_underrun_position", {prev_v_l, l_sv}, 2'b10);
      end
      prev_v_l = l_sv;
    end else prev_v_l = 1'b0;
  end

  initial begin
    int a0, a1, a2, vs;

    #1;
    chk("rst_ser_valid", m_sv, 0);
    chk("rst_ser_out", m_so, 0);
    chk("rst_in_ready", m_rdy, 0);
    chk("rst_frame_k_underrun", {m_fs, m_ko, m_ur}, 3'b000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_release", {m_rdy, l_rdy}, 2'b11);

    // single word 0xA5, MSB first
    vs = vcnt_m;
    push_exp(0, 32'b10100101, 8, 32'h80, 32'h00);
    send(0, 8'hA5, 1'b0, a0);
    m_valid = 1'b0;
    drain(0);
    chk("a5_latency", last_start_m, a0);
    chk("a5_valid_cycles", vcnt_m - vs, 8);
    chk("a5_underrun_count", und_m, 1);

    // back-to-back 0x3C, 0xC3
    vs = vcnt_m;
    push_exp(0, 32'b0011110011000011, 16, 32'h8080, 32'h0000);
    send(0, 8'h3C, 1'b0, a0);
    send(0, 8'hC3, 1'b0, a1);
    m_valid = 1'b0;
    drain(0);
    chk("b2b_valid_cycles", vcnt_m - vs, 16);
    chk("b2b_underrun_count", und_m, 2);

    // LSB-first instance, 0x01
    vs = vcnt_l;
    push_exp(1, 32'b10000000, 8, 32'h80, 32'h00);
    send(1, 8'h01, 1'b0, a0);
    l_valid = 1'b0;
    drain(1);
    chk("lsb_valid_cycles", vcnt_l - vs, 8);
    chk("lsb_underrun_count", und_l, 1);

    // backpressure: three words offered continuously
    vs = vcnt_m;
    push_exp(0, 32'b000100100011010001010110, 24, 32'h808080, 32'h0);
    send(0, 8'h12, 1'b0, a0);
    send(0, 8'h34, 1'b0, a1);
    send(0, 8'h56, 1'b0, a2);
    m_valid = 1'b0;
    drain(0);
    chk("bp_word2_accept_edge", a1 - a0, 1);
    chk("bp_word3_accept_edge", a2 - a0, 9);
    chk("bp_valid_cycles", vcnt_m - vs, 24);
    chk("bp_underrun_count", und_m, 3);

    // K flag: 0xBC as K char, then 0x55 as data
    push_exp(0, 32'b1011110001010101, 16, 32'h8080, 32'hFF00);
    send(0, 8'hBC, 1'b1, a0);
    send(0, 8'h55, 1'b0, a1);
    m_valid = 1'b0;
    drain(0);
    chk("k_underrun_count", und_m, 4);

    // async reset during bit 3 of 0xFF with 0x0F held
    push_exp(0, 32'b1111111100001111, 16, 32'h8080, 32'h0000);
    send(0, 8'hFF, 1'b0, a0);
    send(0, 8'h0F, 1'b0, a1);
    m_valid = 1'b0;
    chk("rst_test_hold_full", m_rdy, 0);
    while (cyc < a0 + 3) @(negedge clk);
    #2;
    reset = 1'b1;
    q_m.delete();
    #1;
    chk("midword_rst_ser_valid", m_sv, 0);
    chk("midword_rst_ser_out", m_so, 0);
    chk("midword_rst_in_ready", m_rdy, 0);
    chk("midword_rst_frame_k", {m_fs, m_ko}, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midword_rst", m_rdy, 1);
    chk("no_underrun_after_rst", und_m, 4);
    vs = vcnt_m;
    push_exp(0, 32'b10000001, 8, 32'h80, 32'h00);
    send(0, 8'h81, 1'b0, a0);
    m_valid = 1'b0;
    drain(0);
    chk("post_rst_latency", last_start_m, a0);
    chk("post_rst_valid_cycles", vcnt_m - vs, 8);
    chk("post_rst_underrun_count", und_m, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
